// File: rtl/keyword_match_multi.sv
`default_nettype none
// ============================================================================
// Module   : keyword_match_multi
// Purpose  : Scans AXI-Stream text frames for any of NUM_KW runtime-loadable
//            keywords at any byte alignment, including across beats, with
//            optional ASCII case folding. One held report per frame.
// Ports    : clk, reset_n (sync, active-low)
//            s_axis_text_* : text stream in (tdata/tkeep/tvalid/tlast/tuser),
//                            tready out
//            cfg_wr_*      : keyword slot write port (en/idx/data/len)
//            match_sig, no_match_sig, match_idx, match_mask : frame report
//            ack           : clears the report
// Revision : 1.0 - initial release
// ============================================================================
module keyword_match_multi #(
  parameter int DATA_WIDTH       = 64,
  parameter int NUM_KW           = 4,
  parameter int KW_MAX_LEN       = 16,
  parameter int CASE_INSENSITIVE = 1,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int IDX_W = (NUM_KW > 1) ? $clog2(NUM_KW) : 1,
  localparam int LEN_W = $clog2(KW_MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_text_tdata,
  input  logic [BYTES-1:0]        s_axis_text_tkeep,
  input  logic                    s_axis_text_tvalid,
  output logic                    s_axis_text_tready,
  input  logic                    s_axis_text_tlast,
  input  logic                    s_axis_text_tuser,
  input  logic                    cfg_wr_en,
  input  logic [IDX_W-1:0]        cfg_wr_idx,
  input  logic [KW_MAX_LEN*8-1:0] cfg_wr_data,
  input  logic [LEN_W-1:0]        cfg_wr_len,
  output logic                    match_sig,
  output logic                    no_match_sig,
  output logic [IDX_W-1:0]        match_idx,
  output logic [NUM_KW-1:0]       match_mask,
  input  logic                    ack
);

  localparam int HIST = KW_MAX_LEN - 1;
  localparam int WIN  = HIST + BYTES;

  typedef enum logic [1:0] {SCAN = 2'd0, DRAIN = 2'd1, REPORT = 2'd2} state_t;
  state_t state, state_nx;

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (CASE_INSENSITIVE != 0 && b >= 8'h41 && b <= 8'h5A) fold = b + 8'h20;
    else fold = b;
  endfunction

  // Keywords are stored folded and reversed: kw[k][0] is the LAST character,
  // so every compare aligns on the window end and needs no length-dependent mux.
  logic [7:0]       kw     [NUM_KW][KW_MAX_LEN];
  logic [LEN_W-1:0] kw_len [NUM_KW];
  logic [7:0]       wr_rev [KW_MAX_LEN];

  always_comb begin
    for (int i = 0; i < KW_MAX_LEN; i++) begin
      wr_rev[i] = 8'h00;
      for (int s = 0; s < KW_MAX_LEN; s++)
        if (s == int'(cfg_wr_len) - 1 - i) wr_rev[i] = fold(cfg_wr_data[8*s +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_KW; k++) kw_len[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KW; k++)
        if (cfg_wr_en && cfg_wr_idx == IDX_W'(k)) kw_len[k] <= cfg_wr_len;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_KW; k++)
      if (cfg_wr_en && cfg_wr_idx == IDX_W'(k))
        for (int i = 0; i < KW_MAX_LEN; i++) kw[k][i] <= wr_rev[i];
  end

  // History: hist[HIST-1] is the newest byte; only the newest hist_cnt
  // entries belong to the current frame.
  logic [7:0]       hist    [HIST];
  logic [7:0]       hist_nx [HIST];
  logic [LEN_W-1:0] hist_cnt, cnt_nx;
  logic [7:0]       win     [WIN];
  int               nvalid;
  logic             accept_en;
  logic             beat;
  logic [NUM_KW-1:0] hit;
  logic [IDX_W-1:0]  low_idx;
  logic              ok;

  assign s_axis_text_tready = accept_en;
  assign beat = s_axis_text_tvalid && accept_en;

  always_comb begin
    nvalid = 0;
    for (int j = 0; j < BYTES; j++) if (s_axis_text_tkeep[j]) nvalid = nvalid + 1;
    for (int p = 0; p < HIST; p++) win[p] = hist[p];
    for (int j = 0; j < BYTES; j++) win[HIST + j] = fold(s_axis_text_tdata[8*j +: 8]);
  end

  // Shift by the number of valid bytes (tkeep is contiguous from bit 0).
  always_comb begin
    for (int p = 0; p < HIST; p++) hist_nx[p] = win[p + nvalid];
    if (int'(hist_cnt) + nvalid >= HIST) cnt_nx = LEN_W'(HIST);
    else cnt_nx = LEN_W'(int'(hist_cnt) + nvalid);
  end

  // Window ending at beat byte j, character i back from the end sits at
  // win[HIST+j-i]; it is in-frame only if i <= j + hist_cnt.
  always_comb begin
    hit = '0;
    ok  = 1'b0;
    for (int k = 0; k < NUM_KW; k++) begin
      if (kw_len[k] != '0 && int'(kw_len[k]) <= KW_MAX_LEN) begin
        for (int j = 0; j < BYTES; j++) begin
          ok = s_axis_text_tkeep[j];
          for (int i = 0; i < KW_MAX_LEN; i++) begin
            if (i < int'(kw_len[k])) begin
              if (i > j + int'(hist_cnt)) ok = 1'b0;
              else if (win[HIST + j - i] != kw[k][i]) ok = 1'b0;
            end
          end
          if (ok) hit[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int k = NUM_KW - 1; k >= 0; k--) if (hit[k]) low_idx = IDX_W'(k);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_cnt <= '0;
      for (int p = 0; p < HIST; p++) hist[p] <= 8'h00;
    end else if (beat) begin
      if (s_axis_text_tlast) begin
        hist_cnt <= '0;
      end else begin
        hist_cnt <= cnt_nx;
        for (int p = 0; p < HIST; p++) hist[p] <= hist_nx[p];
      end
    end
  end

  logic              m_nx, nm_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic [NUM_KW-1:0] mask_nx;

  always_comb begin
    state_nx = state;
    m_nx     = match_sig;
    nm_nx    = no_match_sig;
    idx_nx   = match_idx;
    mask_nx  = match_mask;
    case (state)
      SCAN: begin
        if (beat) begin
          if (|hit) begin
            m_nx     = 1'b1;
            idx_nx   = low_idx;
            mask_nx  = hit;
            state_nx = s_axis_text_tlast ? REPORT : DRAIN;
          end else if (s_axis_text_tlast && !s_axis_text_tuser) begin
            nm_nx    = 1'b1;
            state_nx = REPORT;
          end
        end
      end
      DRAIN: begin
        if (beat && s_axis_text_tlast) state_nx = REPORT;
      end
      REPORT: begin
        if (ack) begin
          m_nx     = 1'b0;
          nm_nx    = 1'b0;
          idx_nx   = '0;
          mask_nx  = '0;
          state_nx = SCAN;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  // tready is registered so it stays low while reset is held and has no
  // path from tvalid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= SCAN;
      accept_en    <= 1'b0;
      match_sig    <= 1'b0;
      no_match_sig <= 1'b0;
      match_idx    <= '0;
      match_mask   <= '0;
    end else begin
      state        <= state_nx;
      accept_en    <= (state_nx != REPORT);
      match_sig    <= m_nx;
      no_match_sig <= nm_nx;
      match_idx    <= idx_nx;
      match_mask   <= mask_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keyword_match_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyword_match_multi
// Purpose  : Self-checking bench for keyword_match_multi. Two instances share
//            all inputs: one case-insensitive, one case-sensitive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keyword_match_multi;

  logic         clk;
  logic         reset_n;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tvalid, tlast, tuser;
  logic         cfg_wr_en;
  logic [1:0]   cfg_wr_idx;
  logic [127:0] cfg_wr_data;
  logic [4:0]   cfg_wr_len;
  logic         ack;

  logic         tready, match_sig, no_match_sig;
  logic [1:0]   match_idx;
  logic [3:0]   match_mask;
  logic         tready_cs, match_sig_cs, no_match_sig_cs;
  logic [1:0]   match_idx_cs;
  logic [3:0]   match_mask_cs;

  int checks = 0;
  int passed = 0;

  keyword_match_multi #(.DATA_WIDTH(64), .NUM_KW(4), .KW_MAX_LEN(16), .CASE_INSENSITIVE(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_text_tdata(tdata), .s_axis_text_tkeep(tkeep), .s_axis_text_tvalid(tvalid),
    .s_axis_text_tready(tready), .s_axis_text_tlast(tlast), .s_axis_text_tuser(tuser),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data), .cfg_wr_len(cfg_wr_len),
    .match_sig(match_sig), .no_match_sig(no_match_sig), .match_idx(match_idx),
    .match_mask(match_mask), .ack(ack)
  );

  keyword_match_multi #(.DATA_WIDTH(64), .NUM_KW(4), .KW_MAX_LEN(16), .CASE_INSENSITIVE(0)) dut_cs (
    .clk(clk), .reset_n(reset_n),
    .s_axis_text_tdata(tdata), .s_axis_text_tkeep(tkeep), .s_axis_text_tvalid(tvalid),
    .s_axis_text_tready(tready_cs), .s_axis_text_tlast(tlast), .s_axis_text_tuser(tuser),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data), .cfg_wr_len(cfg_wr_len),
    .match_sig(match_sig_cs), .no_match_sig(no_match_sig_cs), .match_idx(match_idx_cs),
    .match_mask(match_mask_cs), .ack(ack)
  );

  wire [8:0] obs    = {tready, match_sig, no_match_sig, match_idx, match_mask};
  wire [8:0] obs_cs = {tready_cs, match_sig_cs, no_match_sig_cs, match_idx_cs, match_mask_cs};
  logic [8:0] exp9;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {tready, match, no_match, idx, mask}
  function automatic logic [8:0] ev(input logic t, input logic m, input logic n,
                                    input logic [1:0] i, input logic [3:0] mk);
    return {t, m, n, i, mk};
  endfunction

  function automatic logic [63:0] pk(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 8; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] pkw(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [7:0] lc(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
  endfunction

  function automatic logic [7:0] alpha(input int hi);
    case ($urandom_range(0, hi))
      0: return 8'h61;  // a
      1: return 8'h62;  // b
      2: return 8'h41;  // A
      3: return 8'h42;  // B
      default: return 8'h78;  // x
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wr_kw(input int idx, input string s, input int len);
    cfg_wr_idx  = 2'(idx);
    cfg_wr_data = pkw(s);
    cfg_wr_len  = 5'(len);
    cfg_wr_en   = 1'b1;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic beat_raw(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic beat(input string s, input logic [7:0] k, input logic l, input logic u);
    beat_raw(pk(s), k, l, u);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    exp9 = ev(0, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL reset_hold obs=%b exp=%b", obs, exp9); else passed++;
    tick();
    checks++; if (obs !== exp9) $display("FAIL reset_hold2 obs=%b exp=%b", obs, exp9); else passed++;
    reset_n = 1'b1;
    tick();
    exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL reset_release obs=%b exp=%b", obs, exp9); else passed++;
  endtask

  task automatic test_split_keyword();
    do_reset();
    wr_kw(0, "beginning", 9);
    beat("The BEGI", 8'hFF, 1'b0, 1'b0);
    exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL split_beat0 obs=%b exp=%b", obs, exp9); else passed++;
    beat("NNING.ok", 8'hFF, 1'b1, 1'b0);
    exp9 = ev(0, 1, 0, 2'd0, 4'b0001);
    checks++; if (obs !== exp9) $display("FAIL split_report obs=%b exp=%b", obs, exp9); else passed++;
    repeat (3) tick();
    checks++; if (obs !== exp9) $display("FAIL split_hold obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
    exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL split_ack obs=%b exp=%b", obs, exp9); else passed++;
  endtask

  task automatic test_overlap();
    do_reset();
    wr_kw(0, "beginning", 9);
    wr_kw(1, "ng", 2);
    beat("bbeginni", 8'hFF, 1'b0, 1'b0);
    exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL overlap_beat0 obs=%b exp=%b", obs, exp9); else passed++;
    beat("ng", 8'h03, 1'b1, 1'b0);
    exp9 = ev(0, 1, 0, 2'd0, 4'b0011);
    checks++; if (obs !== exp9) $display("FAIL overlap_report obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
  endtask

  task automatic test_no_match_tuser();
    do_reset();
    wr_kw(0, "cat", 3);
    beat("dog", 8'h07, 1'b1, 1'b0);
    exp9 = ev(0, 0, 1, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL nomatch_report obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
    exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL nomatch_ack obs=%b exp=%b", obs, exp9); else passed++;
    beat("dog", 8'h07, 1'b1, 1'b1);
    checks++; if (obs !== exp9) $display("FAIL tuser_drop obs=%b exp=%b", obs, exp9); else passed++;
    tick();
    checks++; if (obs !== exp9) $display("FAIL tuser_idle obs=%b exp=%b", obs, exp9); else passed++;
  endtask

  task automatic test_early_match_drain();
    do_reset();
    wr_kw(0, "dog", 3);
    wr_kw(1, "cat", 3);
    beat("a dog xy", 8'hFF, 1'b0, 1'b0);
    exp9 = ev(1, 1, 0, 2'd0, 4'b0001);
    checks++; if (obs !== exp9) $display("FAIL drain_beat0 obs=%b exp=%b", obs, exp9); else passed++;
    beat("xxcatxxx", 8'hFF, 1'b0, 1'b0);
    checks++; if (obs !== exp9) $display("FAIL drain_beat1 obs=%b exp=%b", obs, exp9); else passed++;
    beat("zzzzzzzz", 8'hFF, 1'b0, 1'b0);
    checks++; if (obs !== exp9) $display("FAIL drain_beat2 obs=%b exp=%b", obs, exp9); else passed++;
    beat("qq", 8'h03, 1'b1, 1'b1);
    exp9 = ev(0, 1, 0, 2'd0, 4'b0001);
    checks++; if (obs !== exp9) $display("FAIL drain_report obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
  endtask

  task automatic test_config_disable();
    do_reset();
    beat("Ab", 8'h03, 1'b1, 1'b0);
    exp9 = ev(0, 0, 1, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL cfg_all_disabled obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
    wr_kw(2, "Ab", 2);
    beat("ab", 8'h03, 1'b1, 1'b0);
    exp9 = ev(0, 0, 1, 2'd0, 4'b0000);
    checks++; if (obs_cs !== exp9) $display("FAIL cfg_cs_lower obs=%b exp=%b", obs_cs, exp9); else passed++;
    exp9 = ev(0, 1, 0, 2'd2, 4'b0100);
    checks++; if (obs !== exp9) $display("FAIL cfg_ci_lower obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
    beat("Ab", 8'h03, 1'b1, 1'b0);
    exp9 = ev(0, 1, 0, 2'd2, 4'b0100);
    checks++; if (obs_cs !== exp9) $display("FAIL cfg_cs_exact obs=%b exp=%b", obs_cs, exp9); else passed++;
    ack_pulse();
    wr_kw(2, "Ab", 0);
    beat("Ab", 8'h03, 1'b1, 1'b0);
    exp9 = ev(0, 0, 1, 2'd0, 4'b0000);
    checks++; if (obs_cs !== exp9) $display("FAIL cfg_len0 obs=%b exp=%b", obs_cs, exp9); else passed++;
    ack_pulse();
    wr_kw(2, "Ab", 17);
    beat("Ab", 8'h03, 1'b1, 1'b0);
    checks++; if (obs_cs !== exp9) $display("FAIL cfg_len_over obs=%b exp=%b", obs_cs, exp9); else passed++;
    ack_pulse();
  endtask

  task automatic test_reset_midframe();
    do_reset();
    wr_kw(0, "cat", 3);
    wr_kw(1, "dogs", 4);
    beat("a cat do", 8'hFF, 1'b0, 1'b0);
    exp9 = ev(1, 1, 0, 2'd0, 4'b0001);
    checks++; if (obs !== exp9) $display("FAIL rst_drain obs=%b exp=%b", obs, exp9); else passed++;
    reset_n = 1'b0;
    tick();
    exp9 = ev(0, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL rst_outputs obs=%b exp=%b", obs, exp9); else passed++;
    reset_n = 1'b1;
    tick();
    exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL rst_release obs=%b exp=%b", obs, exp9); else passed++;
    wr_kw(1, "dogs", 4);
    beat("gs", 8'h03, 1'b1, 1'b0);
    exp9 = ev(0, 0, 1, 2'd0, 4'b0000);
    checks++; if (obs !== exp9) $display("FAIL rst_no_prefix obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
    beat("cat", 8'h07, 1'b1, 1'b0);
    checks++; if (obs !== exp9) $display("FAIL rst_slots_cleared obs=%b exp=%b", obs, exp9); else passed++;
    ack_pulse();
  endtask

  // Reference: keep every folded byte of the current frame and search it for
  // each enabled keyword as a substring ending inside the newest beat.
  task automatic test_random();
    logic [7:0]   fr[$];
    logic [7:0]   kwb [4][16];
    int           kl [4];
    int           mst;
    logic         em, enm;
    logic [1:0]   eidx;
    logic [3:0]   emask, hm;
    logic [127:0] wd;
    logic [63:0]  d;
    logic [7:0]   k8, b;
    logic         last, user, ok;
    int           idx, r, len, nb, n, base;

    do_reset();
    for (int k = 0; k < 4; k++) kl[k] = 0;
    mst = 0; em = 0; enm = 0; eidx = 0; emask = 0;

    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 3);
        r   = $urandom_range(0, 9);
        len = (r == 0) ? 0 : (r == 1) ? $urandom_range(17, 31) : $urandom_range(1, 4);
        wd  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++)
          if (i < len) begin
            b = alpha(3);
            wd[8*i +: 8] = b;
            kwb[idx][i] = lc(b);
          end
        kl[idx] = len;
        cfg_wr_idx = 2'(idx); cfg_wr_data = wd; cfg_wr_len = 5'(len); cfg_wr_en = 1'b1;
        tick();
        cfg_wr_en = 1'b0;
      end

      nb = $urandom_range(1, 4);
      for (int bi = 0; bi < nb; bi++) begin
        n    = $urandom_range(1, 8);
        k8   = 8'((1 << n) - 1);
        d    = {$urandom, $urandom};
        for (int i = 0; i < n; i++) d[8*i +: 8] = alpha(4);
        last = (bi == nb - 1);
        user = ($urandom_range(0, 3) == 0);
        if (mst == 0) begin
          base = fr.size();
          for (int i = 0; i < n; i++) fr.push_back(lc(d[8*i +: 8]));
          hm = '0;
          for (int k = 0; k < 4; k++)
            if (kl[k] >= 1 && kl[k] <= 16)
              for (int e = base; e < fr.size(); e++)
                if (e + 1 >= kl[k]) begin
                  ok = 1'b1;
                  for (int i = 0; i < kl[k]; i++)
                    if (fr[e - kl[k] + 1 + i] != kwb[k][i]) ok = 1'b0;
                  if (ok) hm[k] = 1'b1;
                end
          if (hm != 0) begin
            em = 1'b1; emask = hm;
            for (int k = 3; k >= 0; k--) if (hm[k]) eidx = 2'(k);
            mst = last ? 2 : 1;
          end else if (last && !user) begin
            enm = 1'b1; mst = 2;
          end
        end else if (mst == 1 && last) begin
          mst = 2;
        end
        if (last) fr.delete();
        beat_raw(d, k8, last, user);
        exp9 = ev(mst != 2, em, enm, eidx, emask);
        checks++; if (obs !== exp9) $display("FAIL rand_beat f=%0d b=%0d obs=%b exp=%b", f, bi, obs, exp9); else passed++;
      end

      if (mst == 2) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          checks++; if (obs !== exp9) $display("FAIL rand_hold f=%0d obs=%b exp=%b", f, obs, exp9); else passed++;
        end
        ack_pulse();
        mst = 0; em = 0; enm = 0; eidx = 0; emask = 0;
        exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
        checks++; if (obs !== exp9) $display("FAIL rand_ack f=%0d obs=%b exp=%b", f, obs, exp9); else passed++;
      end else if ($urandom_range(0, 4) == 0) begin
        ack_pulse();
        exp9 = ev(1, 0, 0, 2'd0, 4'b0000);
        checks++; if (obs !== exp9) $display("FAIL rand_stray_ack f=%0d obs=%b exp=%b", f, obs, exp9); else passed++;
      end
    end
  endtask

  initial begin
    reset_n = 1'b1; tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0; cfg_wr_len = '0; ack = 1'b0;
    test_reset();
    test_split_keyword();
    test_overlap();
    test_no_match_tuser();
    test_early_match_drain();
    test_config_disable();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
